// File: rtl/ipv4_hdr_pkg.sv
// Shared types and IPv4 header constants for the header parser.
// Imported by the parser top and the checksum accumulator.
package ipv4_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FIXED,
        OPTIONS,
        VERDICT
    } state_t;

    typedef enum logic [3:0] {
        ERR_NONE  = 4'd0,
        ERR_VER   = 4'd1,
        ERR_IHL   = 4'd2,
        ERR_LEN   = 4'd3,
        ERR_FRAG  = 4'd4,
        ERR_PROTO = 4'd5,
        ERR_CSUM  = 4'd6,
        ERR_ADDR  = 4'd7,
        ERR_ABORT = 4'd8
    } err_t;

    localparam logic [3:0]  IP_VERSION = 4'd4;
    localparam logic [3:0]  IHL_MIN    = 4'd5;
    localparam logic [5:0]  FIXED_LEN  = 6'd20;
    localparam logic [31:0] BCAST_ADDR = 32'hFFFF_FFFF;
    localparam logic [2:0]  BCAST_IDX  = 3'd7;
    localparam logic [15:0] CSUM_OK    = 16'hFFFF;

    // Byte offsets inside the fixed 20-byte header
    localparam logic [5:0] B_VER_IHL = 6'd0;
    localparam logic [5:0] B_LEN_HI  = 6'd2;
    localparam logic [5:0] B_LEN_LO  = 6'd3;
    localparam logic [5:0] B_FLAGS   = 6'd6;
    localparam logic [5:0] B_FRAG    = 6'd7;
    localparam logic [5:0] B_PROTO   = 6'd9;
    localparam logic [5:0] B_SRC_END = 6'd15;
    localparam logic [5:0] B_DST_END = 6'd19;

    function automatic logic [15:0] csum_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// Ones-complement 16-bit accumulator fed one byte at a time.
// sum already includes the byte presented when it completes a word.
module ip_csum_acc
    import ipv4_hdr_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [15:0] sum
);

    logic [15:0] acc_q;
    logic [7:0]  hi_q;
    logic        odd_q;
    logic [15:0] acc_base;
    logic        odd_base;

    always_comb begin
        acc_base = clear ? 16'd0 : acc_q;
        odd_base = clear ? 1'b0 : odd_q;
        sum      = acc_base;
        if (en && odd_base) begin
            sum = csum_add(acc_base, {hi_q, byte_in});
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q <= '0;
            hi_q  <= '0;
            odd_q <= 1'b0;
        end else begin
            if (clear) begin
                acc_q <= '0;
                odd_q <= 1'b0;
            end
            if (en) begin
                if (odd_base) begin
                    acc_q <= sum;
                end else begin
                    hi_q <= byte_in;
                end
                odd_q <= !odd_base;
            end
        end
    end

endmodule

// File: rtl/ipv4_hdr_parser.sv
// Streaming IPv4 header parser: validates a byte-serial header and
// reports accept/reject one cycle after its last byte.
module ipv4_hdr_parser
    import ipv4_hdr_pkg::*;
#(
    parameter int          NUM_ADDR      = 2,
    parameter bit          ACCEPT_BCAST  = 1'b1,
    parameter bit          ALLOW_OPTIONS = 1'b1,
    parameter bit          CHECK_CSUM    = 1'b1,
    parameter bit          FILTER_SRC    = 1'b0,
    parameter logic [7:0]  PROTO         = 8'h11,
    parameter logic [15:0] MAX_LEN       = 16'h05DC
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [7:0]               data_in,
    input  logic                     data_valid,
    input  logic                     eth_type_ip_valid,
    input  logic [31:0]              ip_s_addr,
    input  logic [32*NUM_ADDR-1:0]   ip_d_addr_list,
    output logic                     ip_header_done,
    output logic                     ip_header_err,
    output logic [3:0]               err_code,
    output logic [31:0]              ip_src_addr,
    output logic [7:0]               ip_protocol,
    output logic [15:0]              ip_payload_len,
    output logic [2:0]               ip_dst_idx
);

    state_t      state_q, state_n;
    logic [5:0]  cnt_q, cnt_n;
    logic [5:0]  hlen_q, hlen_n;
    logic [15:0] tlen_q, tlen_n;
    logic [7:0]  proto_q, proto_n;
    logic [31:0] src_q, src_n;
    logic [23:0] word_q, word_n;
    logic [2:0]  idx_q, idx_n;
    err_t        code_q, code_n;
    logic        abad_q, abad_n;

    logic        done_q, done_n;
    logic        err_q, err_n;
    err_t        ecode_q, ecode_n;
    logic [31:0] osrc_q, osrc_n;
    logic [7:0]  oproto_q, oproto_n;
    logic [15:0] oplen_q, oplen_n;
    logic [2:0]  oidx_q, oidx_n;

    logic        take;
    logic        last;
    logic        csum_clr;
    logic [5:0]  byte_idx;
    logic [15:0] csum;
    logic [31:0] word;
    logic        hit;
    err_t        fin;

    ip_csum_acc u_csum (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (csum_clr),
        .en      (take),
        .byte_in (data_in),
        .sum     (csum)
    );

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        hlen_n   = hlen_q;
        tlen_n   = tlen_q;
        proto_n  = proto_q;
        src_n    = src_q;
        word_n   = word_q;
        idx_n    = idx_q;
        code_n   = code_q;
        abad_n   = abad_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        ecode_n  = ecode_q;
        osrc_n   = osrc_q;
        oproto_n = oproto_q;
        oplen_n  = oplen_q;
        oidx_n   = oidx_q;
        take     = 1'b0;
        last     = 1'b0;
        csum_clr = 1'b0;
        byte_idx = cnt_q;
        word     = {word_q, data_in};
        hit      = 1'b0;
        fin      = ERR_NONE;

        unique case (state_q)
            IDLE: begin
                byte_idx = '0;
                take     = data_valid & eth_type_ip_valid;
                if (take) begin
                    code_n   = ERR_NONE;
                    abad_n   = 1'b0;
                    csum_clr = 1'b1;
                    cnt_n    = 6'd1;
                    state_n  = FIXED;
                end
            end
            FIXED, OPTIONS: begin
                take = data_valid;
                if (!data_valid) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                    ecode_n = ERR_ABORT;
                end else if (cnt_q == hlen_q - 6'd1) begin
                    last = 1'b1;
                end else begin
                    cnt_n = cnt_q + 6'd1;
                    if (cnt_q == B_DST_END) begin
                        state_n = OPTIONS;
                    end
                end
            end
            VERDICT: begin
                state_n = IDLE;
            end
        endcase

        // A recorded failure is never overwritten, so the earliest check wins
        if (take) begin
            word_n = word[23:0];
            case (byte_idx)
                B_VER_IHL: begin
                    if (data_in[7:4] != IP_VERSION) begin
                        code_n = ERR_VER;
                    end
                    if (code_n == ERR_NONE &&
                        (data_in[3:0] < IHL_MIN ||
                         (data_in[3:0] > IHL_MIN && !ALLOW_OPTIONS))) begin
                        code_n = ERR_IHL;
                    end
                    hlen_n = (data_in[3:0] < IHL_MIN) ? FIXED_LEN
                                                      : {data_in[3:0], 2'b00};
                end
                B_LEN_HI: begin
                    tlen_n[15:8] = data_in;
                end
                B_LEN_LO: begin
                    tlen_n = {tlen_q[15:8], data_in};
                    if (code_n == ERR_NONE &&
                        (tlen_n < {10'd0, hlen_q} || tlen_n > MAX_LEN)) begin
                        code_n = ERR_LEN;
                    end
                end
                B_FLAGS: begin
                    if (code_n == ERR_NONE && data_in[5:0] != 6'd0) begin
                        code_n = ERR_FRAG;
                    end
                end
                B_FRAG: begin
                    if (code_n == ERR_NONE && data_in != 8'd0) begin
                        code_n = ERR_FRAG;
                    end
                end
                B_PROTO: begin
                    proto_n = data_in;
                    if (code_n == ERR_NONE && PROTO != 8'hFF &&
                        data_in != PROTO) begin
                        code_n = ERR_PROTO;
                    end
                end
                B_SRC_END: begin
                    src_n = word;
                    if (FILTER_SRC && word != ip_s_addr) begin
                        abad_n = 1'b1;
                    end
                end
                B_DST_END: begin
                    for (int i = NUM_ADDR - 1; i >= 0; i--) begin
                        if (ip_d_addr_list[32*i +: 32] == word) begin
                            hit   = 1'b1;
                            idx_n = 3'(i);
                        end
                    end
                    if (!hit && ACCEPT_BCAST && word == BCAST_ADDR) begin
                        hit   = 1'b1;
                        idx_n = BCAST_IDX;
                    end
                    if (!hit) begin
                        abad_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (last) begin
            fin = code_n;
            if (fin == ERR_NONE && CHECK_CSUM && csum != CSUM_OK) begin
                fin = ERR_CSUM;
            end
            if (fin == ERR_NONE && abad_n) begin
                fin = ERR_ADDR;
            end
            state_n = VERDICT;
            cnt_n   = '0;
            if (fin == ERR_NONE) begin
                done_n   = 1'b1;
                ecode_n  = ERR_NONE;
                osrc_n   = src_n;
                oproto_n = proto_n;
                oplen_n  = tlen_n - {10'd0, hlen_q};
                oidx_n   = idx_n;
            end else begin
                err_n   = 1'b1;
                ecode_n = fin;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hlen_q   <= FIXED_LEN;
            tlen_q   <= '0;
            proto_q  <= '0;
            src_q    <= '0;
            word_q   <= '0;
            idx_q    <= '0;
            code_q   <= ERR_NONE;
            abad_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ecode_q  <= ERR_NONE;
            osrc_q   <= '0;
            oproto_q <= '0;
            oplen_q  <= '0;
            oidx_q   <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            hlen_q   <= hlen_n;
            tlen_q   <= tlen_n;
            proto_q  <= proto_n;
            src_q    <= src_n;
            word_q   <= word_n;
            idx_q    <= idx_n;
            code_q   <= code_n;
            abad_q   <= abad_n;
            done_q   <= done_n;
            err_q    <= err_n;
            ecode_q  <= ecode_n;
            osrc_q   <= osrc_n;
            oproto_q <= oproto_n;
            oplen_q  <= oplen_n;
            oidx_q   <= oidx_n;
        end
    end

    assign ip_header_done = done_q;
    assign ip_header_err  = err_q;
    assign err_code       = ecode_q;
    assign ip_src_addr    = osrc_q;
    assign ip_protocol    = oproto_q;
    assign ip_payload_len = oplen_q;
    assign ip_dst_idx     = oidx_q;

endmodule

// File: tb/tb_ipv4_hdr_parser.sv
// Bench for ipv4_hdr_parser: default instance plus one with options
// disallowed and checksum ignored, both fed the same byte stream.
module tb_ipv4_hdr_parser;
    import ipv4_hdr_pkg::*;

    localparam logic [31:0] SRC   = 32'hC0A8_0002;
    localparam logic [31:0] ADDR0 = 32'hC0A8_0005;
    localparam logic [31:0] ADDR1 = 32'hC0A8_0001;

    typedef struct {
        logic        done;
        logic [3:0]  code;
        logic [31:0] src;
        logic [7:0]  proto;
        logic [15:0] plen;
        logic [2:0]  idx;
        int          cyc;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  data_in = '0;
    logic        data_valid = 1'b0;
    logic        eth = 1'b0;
    logic        eth_hold = 1'b0;
    logic [63:0] addr_list;

    logic        done_a, err_a, done_b, err_b;
    logic [3:0]  code_a, code_b;
    logic [31:0] src_a, src_b;
    logic [7:0]  proto_a, proto_b;
    logic [15:0] plen_a, plen_b;
    logic [2:0]  idx_a, idx_b;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [7:0]  hdr [64];
    int          hlen;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    assign addr_list = {ADDR1, ADDR0};

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    ipv4_hdr_parser dut_a (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .data_in           (data_in),
        .data_valid        (data_valid),
        .eth_type_ip_valid (eth),
        .ip_s_addr         (SRC),
        .ip_d_addr_list    (addr_list),
        .ip_header_done    (done_a),
        .ip_header_err     (err_a),
        .err_code          (code_a),
        .ip_src_addr       (src_a),
        .ip_protocol       (proto_a),
        .ip_payload_len    (plen_a),
        .ip_dst_idx        (idx_a)
    );

    ipv4_hdr_parser #(
        .ALLOW_OPTIONS (1'b0),
        .CHECK_CSUM    (1'b0)
    ) dut_b (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .data_in           (data_in),
        .data_valid        (data_valid),
        .eth_type_ip_valid (eth),
        .ip_s_addr         (SRC),
        .ip_d_addr_list    (addr_list),
        .ip_header_done    (done_b),
        .ip_header_err     (err_b),
        .err_code          (code_b),
        .ip_src_addr       (src_b),
        .ip_protocol       (proto_b),
        .ip_payload_len    (plen_b),
        .ip_dst_idx        (idx_b)
    );

    // Reference verdict computed straight from the header bytes
    function automatic exp_t model(input bit allow, input bit chk);
        exp_t        e;
        logic [3:0]  ihl;
        int          hl;
        logic [15:0] tl;
        logic [15:0] sum;
        logic [16:0] s;
        logic [31:0] dst;
        e = '{default: '0};
        ihl = hdr[0][3:0];
        hl = (ihl < 4'd5) ? 20 : 4 * int'(ihl);
        tl = {hdr[2], hdr[3]};
        sum = '0;
        for (int i = 0; i < hl; i += 2) begin
            s = {1'b0, sum} + {1'b0, hdr[i], hdr[i+1]};
            sum = s[15:0] + {15'd0, s[16]};
        end
        dst = {hdr[16], hdr[17], hdr[18], hdr[19]};
        e.code = ERR_NONE;
        if (hdr[0][7:4] != 4'd4) e.code = ERR_VER;
        else if (ihl < 4'd5 || (ihl > 4'd5 && !allow)) e.code = ERR_IHL;
        else if (int'(tl) < hl || tl > 16'd1500) e.code = ERR_LEN;
        else if (hdr[6][5:0] != 6'd0 || hdr[7] != 8'd0) e.code = ERR_FRAG;
        else if (hdr[9] != 8'h11) e.code = ERR_PROTO;
        else if (chk && sum != 16'hFFFF) e.code = ERR_CSUM;
        else if (dst == ADDR0) e.idx = 3'd0;
        else if (dst == ADDR1) e.idx = 3'd1;
        else if (dst == 32'hFFFF_FFFF) e.idx = 3'd7;
        else e.code = ERR_ADDR;
        e.done = (e.code == ERR_NONE);
        e.src = {hdr[12], hdr[13], hdr[14], hdr[15]};
        e.proto = hdr[9];
        e.plen = tl - 16'(hl);
        return e;
    endfunction

    task automatic build_hdr(input logic [3:0] ihl, input logic [15:0] tl,
                             input logic [15:0] ff, input logic [7:0] pr,
                             input logic [31:0] dst);
        logic [15:0] sum;
        logic [16:0] s;
        hlen = (ihl < 4'd5) ? 20 : 4 * int'(ihl);
        for (int i = 0; i < 64; i++) hdr[i] = 8'(8'hA0 + i);
        hdr[0] = {4'h4, ihl};
        hdr[1] = 8'h00;
        {hdr[2], hdr[3]} = tl;
        {hdr[4], hdr[5]} = 16'h0000;
        {hdr[6], hdr[7]} = ff;
        hdr[8] = 8'h40;
        hdr[9] = pr;
        {hdr[10], hdr[11]} = 16'h0000;
        {hdr[12], hdr[13], hdr[14], hdr[15]} = SRC;
        {hdr[16], hdr[17], hdr[18], hdr[19]} = dst;
        sum = '0;
        for (int i = 0; i < hlen; i += 2) begin
            s = {1'b0, sum} + {1'b0, hdr[i], hdr[i+1]};
            sum = s[15:0] + {15'd0, s[16]};
        end
        {hdr[10], hdr[11]} = ~sum;
    endtask

    // Drive the current header; abort_at >= 0 drops data_valid there
    task automatic send(input int abort_at);
        exp_t ea, eb;
        ea = model(1'b1, 1'b1);
        eb = model(1'b0, 1'b0);
        if (abort_at >= 0) begin
            ea = '{default: '0};
            ea.code = ERR_ABORT;
            eb = ea;
        end
        for (int i = 0; i < hlen; i++) begin
            @(negedge aclk);
            if (i == abort_at) begin
                data_valid = 1'b0;
                eth = 1'b0;
                ea.cyc = cyc + 1;
                eb.cyc = cyc + 1;
                qa.push_back(ea);
                qb.push_back(eb);
                break;
            end
            data_valid = 1'b1;
            eth = (i == 0) || eth_hold;
            data_in = hdr[i];
            if (i == hlen - 1) begin
                ea.cyc = cyc + 1;
                eb.cyc = cyc + 1;
                qa.push_back(ea);
                qb.push_back(eb);
            end
        end
        @(negedge aclk);
        data_valid = 1'b0;
        eth = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge aclk);
    endtask

    always @(negedge aclk) begin
        exp_t e;
        if (aresetn && (done_a || err_a)) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL mon_a unexpected pulse done=%0b err=%0b code=%0d", done_a, err_a, code_a);
            end else begin
                e = qa.pop_front();
                if (done_a !== e.done || err_a !== !e.done || cyc != e.cyc ||
                    (!e.done && code_a !== e.code) ||
                    (e.done && (src_a !== e.src || proto_a !== e.proto ||
                                plen_a !== e.plen || idx_a !== e.idx))) begin
                    errors++;
                    $display("FAIL mon_a got done=%0b err=%0b code=%0d cyc=%0d src=%h proto=%h plen=%0d idx=%0d required done=%0b code=%0d cyc=%0d src=%h proto=%h plen=%0d idx=%0d",
                             done_a, err_a, code_a, cyc, src_a, proto_a, plen_a, idx_a,
                             e.done, e.code, e.cyc, e.src, e.proto, e.plen, e.idx);
                end
            end
        end
        if (aresetn && (done_b || err_b)) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL mon_b unexpected pulse done=%0b err=%0b code=%0d", done_b, err_b, code_b);
            end else begin
                e = qb.pop_front();
                if (done_b !== e.done || err_b !== !e.done || cyc != e.cyc ||
                    (!e.done && code_b !== e.code) ||
                    (e.done && (src_b !== e.src || proto_b !== e.proto ||
                                plen_b !== e.plen || idx_b !== e.idx))) begin
                    errors++;
                    $display("FAIL mon_b got done=%0b err=%0b code=%0d cyc=%0d src=%h proto=%h plen=%0d idx=%0d required done=%0b code=%0d cyc=%0d src=%h proto=%h plen=%0d idx=%0d",
                             done_b, err_b, code_b, cyc, src_b, proto_b, plen_b, idx_b,
                             e.done, e.code, e.cyc, e.src, e.proto, e.plen, e.idx);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        checks++;
        if ({done_a, err_a, code_a, src_a, proto_a, plen_a, idx_a} !== '0) begin
            errors++;
            $display("FAIL reset_a outputs done=%0b err=%0b code=%0d src=%h proto=%h plen=%0d idx=%0d required all 0",
                     done_a, err_a, code_a, src_a, proto_a, plen_a, idx_a);
        end
        checks++;
        if ({done_b, err_b, code_b, src_b, proto_b, plen_b, idx_b} !== '0) begin
            errors++;
            $display("FAIL reset_b outputs done=%0b err=%0b code=%0d required all 0", done_b, err_b, code_b);
        end
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
    endtask

    task automatic test_accept();
        build_hdr(4'd5, 16'd46, 16'h0000, 8'h11, ADDR1);
        send(-1);
        drain();
        checks++;
        if (plen_a !== 16'd26 || idx_a !== 3'd1 || proto_a !== 8'h11 || src_a !== SRC) begin
            errors++;
            $display("FAIL accept_fields plen=%0d idx=%0d proto=%h src=%h required 26 1 11 %h",
                     plen_a, idx_a, proto_a, src_a, SRC);
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL accept_pending qa=%0d qb=%0d required 0", qa.size(), qb.size());
        end
    endtask

    task automatic test_csum();
        build_hdr(4'd5, 16'd46, 16'h0000, 8'h11, ADDR1);
        hdr[11] = hdr[11] ^ 8'h01;
        send(-1);
        drain();
        checks++;
        if (code_a !== ERR_CSUM || code_b !== ERR_NONE) begin
            errors++;
            $display("FAIL csum_codes a=%0d b=%0d required %0d %0d", code_a, code_b, ERR_CSUM, ERR_NONE);
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL csum_pending qa=%0d qb=%0d required 0", qa.size(), qb.size());
        end
    endtask

    task automatic test_options();
        build_hdr(4'd6, 16'd46, 16'h0000, 8'h11, ADDR1);
        send(-1);
        drain();
        checks++;
        if (plen_a !== 16'd22 || code_b !== ERR_IHL) begin
            errors++;
            $display("FAIL options plen_a=%0d code_b=%0d required 22 %0d", plen_a, code_b, ERR_IHL);
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL options_pending qa=%0d qb=%0d required 0", qa.size(), qb.size());
        end
    endtask

    task automatic test_frag_proto();
        build_hdr(4'd5, 16'd46, 16'h2000, 8'h06, ADDR1);
        send(-1);
        drain();
        checks++;
        if (code_a !== ERR_FRAG || code_b !== ERR_FRAG) begin
            errors++;
            $display("FAIL frag_first a=%0d b=%0d required %0d", code_a, code_b, ERR_FRAG);
        end
        build_hdr(4'd5, 16'd46, 16'h4000, 8'h06, ADDR1);
        send(-1);
        drain();
        checks++;
        if (code_a !== ERR_PROTO) begin
            errors++;
            $display("FAIL proto a=%0d required %0d", code_a, ERR_PROTO);
        end
    endtask

    task automatic test_len_bounds();
        logic [15:0] tls [4];
        tls = '{16'd19, 16'd20, 16'd1500, 16'd1501};
        for (int i = 0; i < 4; i++) begin
            build_hdr(4'd5, tls[i], 16'h0000, 8'h11, ADDR0);
            send(-1);
            drain();
        end
        checks++;
        if (code_a !== ERR_LEN || plen_a !== 16'd1480 || idx_a !== 3'd0) begin
            errors++;
            $display("FAIL len_bounds code=%0d plen=%0d idx=%0d required %0d 1480 0",
                     code_a, plen_a, idx_a, ERR_LEN);
        end
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL len_pending qa=%0d qb=%0d required 0", qa.size(), qb.size());
        end
    endtask

    task automatic test_field_errors();
        build_hdr(4'd5, 16'd46, 16'h0000, 8'h11, ADDR1);
        hdr[0] = 8'h65;
        send(-1);
        drain();
        checks++;
        if (code_a !== ERR_VER) begin
            errors++;
            $display("FAIL version code=%0d required %0d", code_a, ERR_VER);
        end
        build_hdr(4'd4, 16'd46, 16'h0000, 8'h11, ADDR1);
        send(-1);
        drain();
        checks++;
        if (code_b !== ERR_IHL) begin
            errors++;
            $display("FAIL ihl_small code=%0d required %0d", code_b, ERR_IHL);
        end
        build_hdr(4'd5, 16'd46, 16'h0000, 8'h11, 32'hC0A8_0009);
        send(-1);
        drain();
        checks++;
        if (code_a !== ERR_ADDR || code_b !== ERR_ADDR) begin
            errors++;
            $display("FAIL addr_miss a=%0d b=%0d required %0d", code_a, code_b, ERR_ADDR);
        end
    endtask

    task automatic test_abort();
        build_hdr(4'd5, 16'd46, 16'h0000, 8'h11, ADDR1);
        send(10);
        drain();
        checks++;
        if (code_a !== ERR_ABORT) begin
            errors++;
            $display("FAIL abort code=%0d required %0d", code_a, ERR_ABORT);
        end
        send(-1);
        drain();
        checks++;
        if (qa.size() != 0 || qb.size() != 0 || plen_a !== 16'd26) begin
            errors++;
            $display("FAIL abort_recover qa=%0d qb=%0d plen=%0d required 0 0 26", qa.size(), qb.size(), plen_a);
        end
    endtask

    task automatic test_back_to_back();
        eth_hold = 1'b1;
        build_hdr(4'd5, 16'd100, 16'h0000, 8'h11, ADDR0);
        send(-1);
        build_hdr(4'd7, 16'd60, 16'h0000, 8'h11, ADDR1);
        send(-1);
        eth_hold = 1'b0;
        drain();
        checks++;
        if (qa.size() != 0 || qb.size() != 0 || plen_a !== 16'd32) begin
            errors++;
            $display("FAIL b2b qa=%0d qb=%0d plen=%0d required 0 0 32", qa.size(), qb.size(), plen_a);
        end
    endtask

    task automatic test_bcast_reset();
        build_hdr(4'd5, 16'd46, 16'h0000, 8'h11, 32'hFFFF_FFFF);
        send(-1);
        drain();
        checks++;
        if (idx_a !== 3'd7 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL bcast idx=%0d done=%0b required 7 0", idx_a, done_a);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge aclk);
            data_valid = 1'b1;
            eth = (i == 0);
            data_in = hdr[i];
        end
        @(negedge aclk);
        aresetn = 1'b0;
        data_valid = 1'b0;
        #1;
        checks++;
        if ({done_a, err_a, code_a, src_a, proto_a, plen_a, idx_a} !== '0 ||
            {done_b, err_b, code_b, src_b, proto_b, plen_b, idx_b} !== '0) begin
            errors++;
            $display("FAIL mid_reset a: idx=%0d plen=%0d code=%0d b: idx=%0d plen=%0d required all 0",
                     idx_a, plen_a, code_a, idx_b, plen_b);
        end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        drain();
        checks++;
        if (qa.size() != 0 || qb.size() != 0 || err_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_pulse qa=%0d qb=%0d err=%0b done=%0b required 0", qa.size(), qb.size(), err_a, done_a);
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_csum();
        test_options();
        test_frag_proto();
        test_len_bounds();
        test_field_errors();
        test_abort();
        test_back_to_back();
        test_bcast_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ipv4_hdr_parser.md
IPV4_HDR_PARSER -- requirements
Module: ipv4_hdr_parser

Interface
REQ-001 SHALL have parameter NUM_ADDR, default 2: number of accepted local destination addresses (1..8).
REQ-002 SHALL have parameter ACCEPT_BCAST, default 1: also accept destination 255.255.255.255.
REQ-003 SHALL have parameter ALLOW_OPTIONS, default 1: accept IHL 6..15; when 0, IHL must equal 5.
REQ-004 SHALL have parameter CHECK_CSUM, default 1: enable header checksum verification.
REQ-005 SHALL have parameter FILTER_SRC, default 0: require source address to equal ip_s_addr.
REQ-006 SHALL have parameter PROTO, default 8'h11: accepted protocol; 8'hFF accepts any.
REQ-007 SHALL have parameter MAX_LEN, default 16'h05DC: maximum accepted total length.
REQ-008 aclk  in  1  clock; one clock domain only.
REQ-009 aresetn  in  1  reset, asynchronous, active-low.
REQ-010 data_in  in  8  header byte stream, network byte order.
REQ-011 data_valid  in  1  byte qualifier; low during a header aborts it.
REQ-012 eth_type_ip_valid  in  1  start qualifier: the byte presented with it high is header byte 0.
REQ-013 ip_s_addr  in  32  expected source address (used when FILTER_SRC=1).
REQ-014 ip_d_addr_list  in  32*NUM_ADDR  local addresses, entry i at bits [32*i+31:32*i].
REQ-015 ip_header_done  out  1  one-cycle pulse: header accepted.
REQ-016 ip_header_err  out  1  one-cycle pulse: header rejected or aborted.
REQ-017 err_code  out  4  reason, valid with ip_header_err, held until next verdict.
REQ-018 ip_src_addr / ip_protocol / ip_payload_len / ip_dst_idx  out  32/8/16/3  parsed fields, valid with ip_header_done, held until next verdict; ip_dst_idx = matched list index, 7 for broadcast.

Function
REQ-019 SHALL use states IDLE, FIXED (bytes 0..19), OPTIONS (bytes 20..IHL*4-1), VERDICT.
REQ-020 IDLE -> FIXED when data_valid & eth_type_ip_valid; that byte is byte 0 and is checked.
REQ-021 SHALL use an 6-bit byte counter over FIXED and OPTIONS; FIXED -> OPTIONS after byte 19 when IHL>5, else -> VERDICT.
REQ-022 OPTIONS -> VERDICT after byte IHL*4-1; option bytes included in checksum, otherwise ignored.
REQ-023 VERDICT lasts one cycle, pulses exactly one of done/err, returns to IDLE; latency = 1 cycle after last header byte.
REQ-024 Checks, first failure wins: version!=4 -> ERR_VER; IHL<5 or (IHL>5 & !ALLOW_OPTIONS) -> ERR_IHL (header then treated as 20 bytes); total length <IHL*4 or >MAX_LEN -> ERR_LEN; MF=1 or offset!=0 -> ERR_FRAG; protocol mismatch -> ERR_PROTO; checksum -> ERR_CSUM; destination/source filter miss -> ERR_ADDR.
REQ-025 On a check failure the block SHALL continue counting to the header end and report at VERDICT.
REQ-026 Checksum: 16-bit ones-complement sum of all header words (end-around carry); pass iff final sum == 16'hFFFF.
REQ-027 Destination match: lowest index i wins among equal entries; broadcast checked only after list miss.
REQ-028 ip_payload_len SHALL equal total length - IHL*4 (16-bit, never negative by REQ-024).
REQ-029 data_valid low in FIXED/OPTIONS SHALL move to IDLE and pulse ip_header_err with ERR_ABORT next cycle; eth_type_ip_valid outside IDLE ignored.
REQ-030 data_valid low in VERDICT SHALL not suppress the verdict pulse.

Reset
REQ-031 aresetn low SHALL asynchronously force IDLE, counter 0, checksum 0, done/err 0, err_code ERR_NONE, all parsed fields 0.
REQ-032 Reset mid-header SHALL discard it with no pulse.

Structure
REQ-033 Package ipv4_hdr_pkg SHALL hold the state enum, 4-bit err enum (ERR_NONE=0, ERR_VER, ERR_IHL, ERR_LEN, ERR_FRAG, ERR_PROTO, ERR_CSUM, ERR_ADDR, ERR_ABORT) and IPv4 field constants.
REQ-034 Checksum accumulator SHALL be a sub-module ip_csum_acc (clear, byte-in, odd/even phase, sum out).

Verification
REQ-035 Header 45 00 00 2E 00 00 00 00 40 11 <valid csum> C0A80002 C0A80001, list[1]=C0A80001 -> done 1 cycle after last byte, ip_dst_idx=1, payload_len=26, protocol 11.
REQ-036 Same header with checksum byte flipped -> err, err_code ERR_CSUM; with CHECK_CSUM=0 -> done.
REQ-037 IHL=6 with 4 option bytes, ALLOW_OPTIONS=1 -> done after byte 23; ALLOW_OPTIONS=0 -> err ERR_IHL after byte 23.
REQ-038 Flags/offset 20 00 (MF) and protocol 06 together -> err ERR_FRAG (first wins).
REQ-039 data_valid dropped at byte 10 -> ERR_ABORT pulse next cycle; following valid header accepted normally.
REQ-040 Destination FFFFFFFF, ACCEPT_BCAST=1 -> done, ip_dst_idx=7; aresetn low at byte 15 -> no pulse, outputs 0.
